// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
// master: the requester that also plays the instruction memory.
// slave: the encoder itself.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, target, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, target, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Symbolic-instruction to MIPS word encoder. Accepts one request at a time,
// packs it into a 32-bit word and writes it to sequential instruction-memory
// addresses, holding the write until the memory acknowledges it.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  instr_encoder_if.slave  bus,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [4:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLL, M_SRL, M_JR,
    M_MUL,
    M_LW, M_LH, M_LB, M_SW, M_SH, M_SB,
    M_BGEZ, M_BLTZ,
    M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_J, M_JAL,
    M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI
  } mnem_e;

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  typedef struct packed {
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  req_t          req;
  logic [31:0]   enc;
  logic          legal;
  state_e        state;
  logic [ADDR_W:0] count_inc;

  assign req = '{mnem: bus.mnem, rs: bus.rs, rt: bus.rt, rd: bus.rd,
                 shamt: bus.shamt, imm: bus.imm, target: bus.target};
  assign count_inc = count + (ADDR_W+1)'(1);

  // Field packing per mnemonic; unused fields are forced to zero so the word
  // matches what the controller's decoder expects.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (req.mnem)
      M_ADD:  enc = r_word(6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h20);
      M_SUB:  enc = r_word(6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h22);
      M_AND:  enc = r_word(6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h24);
      M_OR:   enc = r_word(6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h25);
      M_XOR:  enc = r_word(6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h26);
      M_NOR:  enc = r_word(6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h27);
      M_SLT:  enc = r_word(6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h2A);
      M_SLL:  enc = r_word(6'h00, 5'd0, req.rt, req.rd, req.shamt, 6'h00);
      M_SRL:  enc = r_word(6'h00, 5'd0, req.rt, req.rd, req.shamt, 6'h02);
      M_JR:   enc = r_word(6'h00, req.rs, 5'd0, 5'd0, 5'd0, 6'h08);
      M_MUL:  enc = r_word(6'h1C, req.rs, req.rt, req.rd, 5'd0, 6'h02);
      M_LW:   enc = i_word(6'h23, req.rs, req.rt, req.imm);
      M_LH:   enc = i_word(6'h21, req.rs, req.rt, req.imm);
      M_LB:   enc = i_word(6'h20, req.rs, req.rt, req.imm);
      M_SW:   enc = i_word(6'h2B, req.rs, req.rt, req.imm);
      M_SH:   enc = i_word(6'h29, req.rs, req.rt, req.imm);
      M_SB:   enc = i_word(6'h28, req.rs, req.rt, req.imm);
      M_BGEZ: enc = i_word(6'h01, req.rs, 5'd1, req.imm);
      M_BLTZ: enc = i_word(6'h01, req.rs, 5'd0, req.imm);
      M_BEQ:  enc = i_word(6'h04, req.rs, req.rt, req.imm);
      M_BNE:  enc = i_word(6'h05, req.rs, req.rt, req.imm);
      M_BLEZ: enc = i_word(6'h06, req.rs, 5'd0, req.imm);
      M_BGTZ: enc = i_word(6'h07, req.rs, 5'd0, req.imm);
      M_J:    enc = {6'h02, req.target};
      M_JAL:  enc = {6'h03, req.target};
      M_ADDI: enc = i_word(6'h08, req.rs, req.rt, req.imm);
      M_ANDI: enc = i_word(6'h0C, req.rs, req.rt, req.imm);
      M_ORI:  enc = i_word(6'h0D, req.rs, req.rt, req.imm);
      M_XORI: enc = i_word(6'h0E, req.rs, req.rt, req.imm);
      M_SLTI: enc = i_word(6'h0A, req.rs, req.rt, req.imm);
      default: legal = 1'b0;
    endcase
  end

  // Accept/write FSM with registered handshake, address and status outputs.
  // Clear outranks both a pending MemAck and a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      count         <= '0;
      full          <= 1'b0;
      err           <= 1'b0;
    end else if (clear) begin
      state         <= S_IDLE;
      bus.in_ready  <= (DEPTH_C != '0);
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      count         <= '0;
      full          <= (DEPTH_C == '0);
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.in_ready <= !full;
          if (bus.in_valid && bus.in_ready) begin
            if (legal) begin
              bus.mem_wdata <= enc;
              bus.mem_we    <= 1'b1;
              bus.in_ready  <= 1'b0;
              state         <= S_WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            if (count != DEPTH_C) begin
              count        <= count_inc;
              full         <= (count_inc == DEPTH_C);
              bus.in_ready <= (count_inc != DEPTH_C);
            end else begin
              bus.in_ready <= 1'b0;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
